// File: rtl/timing_trigger_gen.sv
// Tester-cycle trigger generator: decodes per-signal waveform characters into edge triggers.
// Optional build macro TRIG_EVENT_COUNT_EN adds one saturating event counter per trigger.
module timing_trigger_gen #(
    parameter int NUM_SIG   = 23,
    parameter int NUM_EDGE  = 3,
    parameter int WFT_W     = 4,
    parameter int WFC_W     = 8,
    parameter int CNT_W     = 16,
    parameter int TRIG_MODE = 0,
    localparam int NUM_TRIG = NUM_SIG * NUM_EDGE,
    localparam int SEL_W    = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
    input  logic                     tester_sync,
    input  logic                     tester_reset,
    input  logic                     sync_en,
    input  logic [WFT_W-1:0]         cfg_wft,
    input  logic [WFT_W-1:0]         wft,
    input  logic [NUM_SIG*WFC_W-1:0] wfc,
    output logic [NUM_TRIG-1:0]      triggers,
    input  logic [SEL_W-1:0]         cnt_sel,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         cnt_val
);

    logic                     en_r;
    logic [WFT_W-1:0]         wft_r;
    logic [WFT_W-1:0]         cfg_wft_r;
    logic [NUM_SIG*WFC_W-1:0] wfc_r;
    logic [NUM_TRIG-1:0]      fire_s;
    logic [NUM_TRIG-1:0]      triggers_r;

    // Stage 1: sample the qualifier, table codes and waveform characters.
    always_ff @(posedge tester_sync) begin
        if (tester_reset) begin
            en_r      <= 1'b0;
            wft_r     <= '0;
            cfg_wft_r <= '0;
            wfc_r     <= '0;
        end else begin
            en_r      <= sync_en;
            wft_r     <= wft;
            cfg_wft_r <= cfg_wft;
            wfc_r     <= wfc;
        end
    end

    // Match decode; an unknown operand drives the if down its else branch, so X never fires.
    always_comb begin
        fire_s = '0;
        for (int s = 0; s < NUM_SIG; s++) begin
            for (int e = 0; e < NUM_EDGE; e++) begin
                if (en_r && (wft_r == cfg_wft_r) &&
                    (wfc_r[s*WFC_W +: WFC_W] == WFC_W'(e + 1))) begin
                    fire_s[s*NUM_EDGE + e] = 1'b1;
                end else begin
                    fire_s[s*NUM_EDGE + e] = 1'b0;
                end
            end
        end
    end

    // Stage 2: toggle or pulse each trigger from the decoded firings.
    always_ff @(posedge tester_sync) begin
        if (tester_reset) begin
            triggers_r <= '0;
        end else if (TRIG_MODE == 0) begin
            triggers_r <= triggers_r ^ fire_s;
        end else begin
            triggers_r <= fire_s;
        end
    end

    assign triggers = triggers_r;

`ifdef TRIG_EVENT_COUNT_EN
    logic [CNT_W-1:0] cnt_r [NUM_TRIG];
    logic [CNT_W-1:0] cnt_val_r;

    // Saturating per-trigger event counters; a clear overrides a coincident firing.
    always_ff @(posedge tester_sync) begin
        if (tester_reset || cnt_clr) begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                if (fire_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Registered counter read port; indices past the last trigger read as zero.
    always_ff @(posedge tester_sync) begin
        if (tester_reset) begin
            cnt_val_r <= '0;
        end else if (32'(cnt_sel) < 32'(NUM_TRIG)) begin
            cnt_val_r <= cnt_r[cnt_sel];
        end else begin
            cnt_val_r <= '0;
        end
    end

    assign cnt_val = cnt_val_r;
`else
    logic unused_cnt_s;
    assign unused_cnt_s = ^{cnt_sel, cnt_clr};
    assign cnt_val      = '0;
`endif

endmodule
